// File: rtl/csa_regmap_pkg.sv
// csa_regmap_pkg
// Register map and shared types for csa_ram and its register-bus sequencer.
// Contents:
//   - fixed register addresses (BUSY, READY, CH, IN_VALID, IN_DATA0)
//   - address helpers for the registers whose position depends on IN_REGS/OUT_REGS
//   - sequencer state enum and read-tag kind enum
//   - lane width helper (data width split evenly over a register group)
package csa_regmap_pkg;

    localparam int unsigned ADDR_BUSY     = 32'd0;
    localparam int unsigned ADDR_READY    = 32'd1;
    localparam int unsigned ADDR_CH       = 32'd2;
    localparam int unsigned ADDR_IN_VALID = 32'd3;
    localparam int unsigned ADDR_IN_DATA0 = 32'd4;

    function automatic int unsigned addr_out_valid(input int unsigned in_regs);
        return 32'd4 + in_regs;
    endfunction

    function automatic int unsigned addr_out_data0(input int unsigned in_regs);
        return 32'd5 + in_regs;
    endfunction

    function automatic int unsigned addr_calc_times(input int unsigned in_regs,
                                                    input int unsigned out_regs);
        return 32'd5 + in_regs + out_regs;
    endfunction

    // Bits of a wide value carried by each register of a group.
    function automatic int unsigned lane_w(input int unsigned width,
                                           input int unsigned regs);
        return width / regs;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_CALC   = 4'd1,
        S_WR_CH     = 4'd2,
        S_POLL      = 4'd3,
        S_PUSH      = 4'd4,
        S_RD_IV     = 4'd5,
        S_BURST_IN  = 4'd6,
        S_RD_OV     = 4'd7,
        S_BURST_OUT = 4'd8,
        S_NEXT      = 4'd9,
        S_ERR       = 4'd10
    } seq_state_e;

    // What an in-flight read is for: a status word or a data lane.
    typedef enum logic [1:0] {
        TAG_STAT = 2'd0,
        TAG_IN   = 2'd1,
        TAG_OUT  = 2'd2
    } rd_kind_e;

endpackage

// File: rtl/csa_rd_capture.sv
// csa_rd_capture
// Tracks register reads through the fixed read latency and routes returning
// data either back to the sequencer (status reads) or into one lane of the
// assembled input/output result registers.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   iss_valid/kind/idx  read issued this cycle (aligned with ren) and its tag
//   rdata               register read data
//   stat_valid          a status read result is on rdata this cycle
//   pipe_empty          no read is in flight
//   res_in, res_out     assembled lanes, held until overwritten
module csa_rd_capture
    import csa_regmap_pkg::*;
#(
    parameter int DW         = 32,
    parameter int IN_W       = 40,
    parameter int OUT_W      = 48,
    parameter int IN_REGS    = 5,
    parameter int OUT_REGS   = 3,
    parameter int RD_LATENCY = 2,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  rd_kind_e          iss_kind,
    input  logic [IDX_W-1:0]  iss_idx,
    input  logic [DW-1:0]     rdata,
    output logic              stat_valid,
    output logic              pipe_empty,
    output logic [IN_W-1:0]   res_in,
    output logic [OUT_W-1:0]  res_out
);
    localparam int LIN  = lane_w(IN_W, IN_REGS);
    localparam int LOUT = lane_w(OUT_W, OUT_REGS);
    localparam int L    = RD_LATENCY;

    logic [L-1:0]     v_q, v_d;
    rd_kind_e         kind_q [L];
    rd_kind_e         kind_d [L];
    logic [IDX_W-1:0] idx_q  [L];
    logic [IDX_W-1:0] idx_d  [L];
    logic [IN_W-1:0]  res_in_q, res_in_d;
    logic [OUT_W-1:0] res_out_q, res_out_d;

    // Tag shift and lane demux; the last stage lines up with valid rdata.
    always_comb begin
        v_d       = {v_q[L-2+1-1:0], iss_valid} ;
        kind_d[0] = iss_kind;
        idx_d[0]  = iss_idx;
        for (int k = 1; k < L; k++) begin
            kind_d[k] = kind_q[k-1];
            idx_d[k]  = idx_q[k-1];
        end
        res_in_d  = res_in_q;
        res_out_d = res_out_q;
        if (v_q[L-1] && (kind_q[L-1] == TAG_IN)) begin
            for (int k = 0; k < IN_REGS; k++) begin
                if (idx_q[L-1] == IDX_W'(k)) begin
                    res_in_d[k*LIN +: LIN] = rdata[LIN-1:0];
                end else begin
                    res_in_d[k*LIN +: LIN] = res_in_q[k*LIN +: LIN];
                end
            end
        end else if (v_q[L-1] && (kind_q[L-1] == TAG_OUT)) begin
            for (int k = 0; k < OUT_REGS; k++) begin
                if (idx_q[L-1] == IDX_W'(k)) begin
                    res_out_d[k*LOUT +: LOUT] = rdata[LOUT-1:0];
                end else begin
                    res_out_d[k*LOUT +: LOUT] = res_out_q[k*LOUT +: LOUT];
                end
            end
        end else begin
            res_in_d  = res_in_q;
            res_out_d = res_out_q;
        end
    end

    // Tag pipeline and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q       <= '0;
            res_in_q  <= '0;
            res_out_q <= '0;
            for (int k = 0; k < L; k++) begin
                kind_q[k] <= TAG_STAT;
                idx_q[k]  <= '0;
            end
        end else begin
            v_q       <= v_d;
            res_in_q  <= res_in_d;
            res_out_q <= res_out_d;
            for (int k = 0; k < L; k++) begin
                kind_q[k] <= kind_d[k];
                idx_q[k]  <= idx_d[k];
            end
        end
    end

    assign stat_valid = v_q[L-1] && (kind_q[L-1] == TAG_STAT);
    assign pipe_empty = ~|v_q;
    assign res_in     = res_in_q;
    assign res_out    = res_out_q;

endmodule

// File: rtl/csa_ram_seq_driver.sv
// csa_ram_seq_driver
// Register-bus sequencer for csa_ram: programs CALC_TIMES and CHANNEL_INDEX,
// polls BUSY, pushes a counting pattern into the CSA input FIFO, then
// burst-reads the IN/OUT data registers of each channel and strobes the
// assembled result. One-shot or continuous over cfg_num_ch channels.
// Ports:
//   csa_in_wclk, rst_n        clock, synchronous active-low reset
//   start, cfg_*              sequence start and configuration (latched on start)
//   wen/waddr/wdata           register write, one-cycle pulse
//   ren/raddr/rdata           register read, data RD_LATENCY cycles after ren
//   csa_in_wen/csa_in_wdata   FIFO push; csa_in_error_full stalls pushes
//   res_valid/res_ch/res_in/res_out  per-channel result
//   busy, done, err_timeout   status
module csa_ram_seq_driver
    import csa_regmap_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int CSA_CALC_IN_WIDTH  = 40,
    parameter int CSA_CALC_OUT_WIDTH = 48,
    parameter int IN_REGS            = 5,
    parameter int OUT_REGS           = 3,
    parameter int MAX_CHANNELS       = 4,
    parameter int RD_LATENCY         = 2,
    parameter int POLL_TIMEOUT       = 1024,
    localparam int CH_BITS           = $clog2(MAX_CHANNELS)
) (
    input  logic                          csa_in_wclk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          cfg_loop,
    input  logic [31:0]                   cfg_calc_times,
    input  logic [CH_BITS:0]              cfg_num_ch,
    input  logic [15:0]                   cfg_words,
    input  logic [CSA_CALC_IN_WIDTH-1:0]  cfg_seed,
    output logic                          wen,
    output logic [OPT_MEM_ADDR_BITS-1:0]  waddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] wdata,
    output logic                          ren,
    output logic [OPT_MEM_ADDR_BITS-1:0]  raddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] rdata,
    output logic                          csa_in_wen,
    output logic [CSA_CALC_IN_WIDTH-1:0]  csa_in_wdata,
    input  logic                          csa_in_error_full,
    output logic                          res_valid,
    output logic [CH_BITS-1:0]            res_ch,
    output logic [CSA_CALC_IN_WIDTH-1:0]  res_in,
    output logic [CSA_CALC_OUT_WIDTH-1:0] res_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err_timeout
);
    localparam int AW     = OPT_MEM_ADDR_BITS;
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int IW     = CSA_CALC_IN_WIDTH;
    localparam int IDX_W  = $clog2(((IN_REGS > OUT_REGS) ? IN_REGS : OUT_REGS) + 1);
    localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);
    localparam int NCH_W  = CH_BITS + 1;

    seq_state_e         state_q, state_d;
    logic [CH_BITS-1:0] ch_q, ch_d;
    logic [NCH_W-1:0]   num_ch_q, num_ch_d;
    logic [31:0]        calc_q, calc_d;
    logic [15:0]        words_q, words_d, word_q, word_d;
    logic [IW-1:0]      pattern_q, pattern_d;
    logic [POLL_W-1:0]  poll_q, poll_d;
    logic [IDX_W-1:0]   idx_q, idx_d, rd_idx_q, rd_idx_d;
    logic               pend_q, pend_d, loop_q, loop_d;
    logic               wen_q, wen_d, ren_q, ren_d, fwen_q, fwen_d;
    logic [AW-1:0]      waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [IW-1:0]      fdata_q, fdata_d;
    rd_kind_e           rd_kind_q, rd_kind_d;
    logic               res_valid_q, res_valid_d, busy_q, busy_d;
    logic               done_q, done_d, err_q, err_d;
    logic [CH_BITS-1:0] res_ch_q, res_ch_d;
    logic               cap_stat_valid, cap_empty;

    // Sequencer next-state and output decode.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        num_ch_d    = num_ch_q;
        calc_d      = calc_q;
        words_d     = words_q;
        word_d      = word_q;
        pattern_d   = pattern_q;
        poll_d      = poll_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        loop_d      = loop_q;
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        ren_d       = 1'b0;
        raddr_d     = raddr_q;
        rd_kind_d   = rd_kind_q;
        rd_idx_d    = rd_idx_q;
        fwen_d      = 1'b0;
        fdata_d     = fdata_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            // IDLE and ERR both wait for start; start also clears a timeout.
            S_IDLE, S_ERR: begin
                if (start) begin
                    calc_d    = cfg_calc_times;
                    words_d   = cfg_words;
                    loop_d    = cfg_loop;
                    pattern_d = cfg_seed;
                    ch_d      = '0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    state_d   = S_WR_CALC;
                    if (cfg_num_ch == NCH_W'(0)) begin
                        num_ch_d = NCH_W'(1);
                    end else if (cfg_num_ch > NCH_W'(MAX_CHANNELS)) begin
                        num_ch_d = NCH_W'(MAX_CHANNELS);
                    end else begin
                        num_ch_d = cfg_num_ch;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_WR_CALC: begin
                wen_d   = 1'b1;
                waddr_d = AW'(addr_calc_times(IN_REGS, OUT_REGS));
                wdata_d = DW'(calc_q);
                state_d = S_WR_CH;
            end
            S_WR_CH: begin
                wen_d   = 1'b1;
                waddr_d = AW'(ADDR_CH);
                wdata_d = DW'(ch_q);
                poll_d  = '0;
                pend_d  = 1'b0;
                word_d  = 16'd0;
                state_d = S_POLL;
            end
            S_POLL: begin
                if (!pend_q) begin
                    ren_d     = 1'b1;
                    raddr_d   = AW'(ADDR_BUSY);
                    rd_kind_d = TAG_STAT;
                    pend_d    = 1'b1;
                end else if (cap_stat_valid) begin
                    if (rdata == '0) begin
                        pend_d  = 1'b0;
                        state_d = (words_q == 16'd0) ? S_RD_IV : S_PUSH;
                    end else if ((poll_q + POLL_W'(1)) == POLL_W'(POLL_TIMEOUT)) begin
                        poll_d  = poll_q + POLL_W'(1);
                        pend_d  = 1'b0;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        // Still busy: reissue in the same cycle the answer lands.
                        poll_d    = poll_q + POLL_W'(1);
                        ren_d     = 1'b1;
                        raddr_d   = AW'(ADDR_BUSY);
                        rd_kind_d = TAG_STAT;
                    end
                end else begin
                    pend_d = pend_q;
                end
            end
            S_PUSH: begin
                if (!csa_in_error_full) begin
                    fwen_d    = 1'b1;
                    fdata_d   = pattern_q;
                    pattern_d = pattern_q + IW'(1);
                    word_d    = word_q + 16'd1;
                    if ((word_q + 16'd1) == words_q) begin
                        state_d = S_RD_IV;
                    end else begin
                        state_d = S_PUSH;
                    end
                end else begin
                    state_d = S_PUSH;
                end
            end
            S_RD_IV, S_RD_OV: begin
                if (!pend_q) begin
                    ren_d     = 1'b1;
                    raddr_d   = (state_q == S_RD_IV) ? AW'(ADDR_IN_VALID)
                                                     : AW'(addr_out_valid(IN_REGS));
                    rd_kind_d = TAG_STAT;
                    pend_d    = 1'b1;
                end else if (cap_stat_valid) begin
                    pend_d = 1'b0;
                    idx_d  = '0;
                    if (rdata == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = (state_q == S_RD_IV) ? S_BURST_IN : S_BURST_OUT;
                    end
                end else begin
                    pend_d = pend_q;
                end
            end
            S_BURST_IN: begin
                if (idx_q < IDX_W'(IN_REGS)) begin
                    ren_d     = 1'b1;
                    raddr_d   = AW'(ADDR_IN_DATA0) + AW'(idx_q);
                    rd_kind_d = TAG_IN;
                    rd_idx_d  = idx_q;
                    idx_d     = idx_q + IDX_W'(1);
                end else if (!ren_q && cap_empty) begin
                    state_d = S_RD_OV;
                end else begin
                    state_d = S_BURST_IN;
                end
            end
            S_BURST_OUT: begin
                if (idx_q < IDX_W'(OUT_REGS)) begin
                    ren_d     = 1'b1;
                    raddr_d   = AW'(addr_out_data0(IN_REGS)) + AW'(idx_q);
                    rd_kind_d = TAG_OUT;
                    rd_idx_d  = idx_q;
                    idx_d     = idx_q + IDX_W'(1);
                end else if (!ren_q && cap_empty) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_q;
                    state_d     = S_NEXT;
                end else begin
                    state_d = S_BURST_OUT;
                end
            end
            S_NEXT: begin
                if ((NCH_W'(ch_q) + NCH_W'(1)) < num_ch_q) begin
                    ch_d    = ch_q + CH_BITS'(1);
                    state_d = S_WR_CH;
                end else begin
                    done_d = 1'b1;
                    ch_d   = '0;
                    if (loop_q) begin
                        state_d = S_WR_CALC;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge csa_in_wclk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            num_ch_q    <= '0;
            calc_q      <= 32'd0;
            words_q     <= 16'd0;
            word_q      <= 16'd0;
            pattern_q   <= '0;
            poll_q      <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            loop_q      <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            rd_kind_q   <= TAG_STAT;
            rd_idx_q    <= '0;
            fwen_q      <= 1'b0;
            fdata_q     <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            num_ch_q    <= num_ch_d;
            calc_q      <= calc_d;
            words_q     <= words_d;
            word_q      <= word_d;
            pattern_q   <= pattern_d;
            poll_q      <= poll_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            loop_q      <= loop_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            rd_kind_q   <= rd_kind_d;
            rd_idx_q    <= rd_idx_d;
            fwen_q      <= fwen_d;
            fdata_q     <= fdata_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    csa_rd_capture #(
        .DW         (DW),
        .IN_W       (CSA_CALC_IN_WIDTH),
        .OUT_W      (CSA_CALC_OUT_WIDTH),
        .IN_REGS    (IN_REGS),
        .OUT_REGS   (OUT_REGS),
        .RD_LATENCY (RD_LATENCY),
        .IDX_W      (IDX_W)
    ) u_rd_capture (
        .clk        (csa_in_wclk),
        .rst_n      (rst_n),
        .iss_valid  (ren_q),
        .iss_kind   (rd_kind_q),
        .iss_idx    (rd_idx_q),
        .rdata      (rdata),
        .stat_valid (cap_stat_valid),
        .pipe_empty (cap_empty),
        .res_in     (res_in),
        .res_out    (res_out)
    );

    assign wen          = wen_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign ren          = ren_q;
    assign raddr        = raddr_q;
    assign csa_in_wen   = fwen_q;
    assign csa_in_wdata = fdata_q;
    assign res_valid    = res_valid_q;
    assign res_ch       = res_ch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_csa_ram_seq_driver.sv
module tb_csa_ram_seq_driver;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, cfg_loop, csa_in_error_full;
    logic [31:0] cfg_calc_times;
    logic [2:0]  cfg_num_ch;
    logic [15:0] cfg_words;
    logic [39:0] cfg_seed;
    logic        wen, ren, csa_in_wen, res_valid, busy, done, err_timeout;
    logic [9:0]  waddr, raddr;
    logic [31:0] wdata, rdata;
    logic [39:0] csa_in_wdata, res_in;
    logic [47:0] res_out;
    logic [1:0]  res_ch;

    always #5 clk = ~clk;

    csa_ram_seq_driver #(.POLL_TIMEOUT(8)) dut (
        .csa_in_wclk(clk), .rst_n(rst_n), .start(start), .cfg_loop(cfg_loop),
        .cfg_calc_times(cfg_calc_times), .cfg_num_ch(cfg_num_ch), .cfg_words(cfg_words),
        .cfg_seed(cfg_seed), .wen(wen), .waddr(waddr), .wdata(wdata), .ren(ren),
        .raddr(raddr), .rdata(rdata), .csa_in_wen(csa_in_wen), .csa_in_wdata(csa_in_wdata),
        .csa_in_error_full(csa_in_error_full), .res_valid(res_valid), .res_ch(res_ch),
        .res_in(res_in), .res_out(res_out), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    // Register model
    logic [7:0]  in_lane  [4][5];
    logic [15:0] out_lane [4][3];
    logic        in_v [4];
    logic        out_v [4];
    int          busy_cfg;
    logic [1:0]  cur_ch = 2'd0;
    logic        pv [L];
    logic [31:0] pd [L];
    int          cyc = 0;

    // Logs
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          busy_rd [$];
    logic [39:0] fifo [$];
    logic [1:0]  r_ch [$];
    logic [39:0] r_in [$];
    logic [47:0] r_out [$];
    int          done_cnt = 0;
    int          pulse_cnt = 0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] reg_val(input logic [9:0] a, input int nbusy);
        logic [31:0] v;
        if (a == 10'd0)                      v = (nbusy <= busy_cfg) ? 32'd1 : 32'd0;
        else if (a == 10'd3)                 v = {31'd0, in_v[cur_ch]};
        else if (a >= 10'd4 && a <= 10'd8)   v = {24'hABCDEF, in_lane[cur_ch][a - 10'd4]};
        else if (a == 10'd9)                 v = {31'd0, out_v[cur_ch]};
        else if (a >= 10'd10 && a <= 10'd12) v = {16'hBEEF, out_lane[cur_ch][a - 10'd10]};
        else                                 v = 32'hDEAD_0000;
        return v;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wen && waddr == 10'd2) cur_ch <= wdata[1:0];
        pv[0] <= ren;
        pd[0] <= ren ? reg_val(raddr, busy_rd.size()) : 32'd0;
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign rdata = pv[L-1] ? pd[L-1] : 32'h0;

    always @(negedge clk) begin
        if (wen) begin wr_addr.push_back(waddr); wr_data.push_back(wdata); end
        if (ren && raddr == 10'd0) busy_rd.push_back(cyc);
        if (csa_in_wen) fifo.push_back(csa_in_wdata);
        if (res_valid) begin r_ch.push_back(res_ch); r_in.push_back(res_in); r_out.push_back(res_out); end
        if (done) done_cnt = done_cnt + 1;
        if (wen || ren || csa_in_wen) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); busy_rd.delete(); fifo.delete();
        r_ch.delete(); r_in.delete(); r_out.delete(); done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt > 0 || err_timeout) begin ok = 1'b1; break; end
        end
        check({tag, "_ended"}, {63'd0, ok}, 64'd1);
        @(negedge clk);
    endtask

    task automatic check_first_pass(input string tag);
        check({tag, "_nwr"}, wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check({tag, "_wr0a"}, wr_addr[0], 10'd13);
            check({tag, "_wr0d"}, wr_data[0], 32'h55);
            check({tag, "_wr1a"}, wr_addr[1], 10'd2);
            check({tag, "_wr1d"}, wr_data[1], 32'd0);
        end
        check({tag, "_nfifo"}, fifo.size(), 2);
        if (fifo.size() == 2) begin
            check({tag, "_fifo0"}, fifo[0], 40'h0);
            check({tag, "_fifo1"}, fifo[1], 40'h1);
        end
        check({tag, "_nres"}, r_in.size(), 1);
        if (r_in.size() == 1) begin
            check({tag, "_res_ch"}, r_ch[0], 2'd0);
            check({tag, "_res_in"}, r_in[0], 40'h12_3456_7890);
            check({tag, "_res_out"}, r_out[0], 48'h1111_2222_3333);
        end
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    initial begin
        logic ok;
        logic sp_ok;
        rst_n = 1'b0; start = 1'b0; cfg_loop = 1'b0; csa_in_error_full = 1'b0;
        cfg_calc_times = 32'h55; cfg_num_ch = 3'd1; cfg_words = 16'd2; cfg_seed = 40'h0;
        busy_cfg = 0;
        for (int c = 0; c < 4; c++) begin
            in_v[c] = 1'b1; out_v[c] = 1'b1;
            for (int k = 0; k < 5; k++) in_lane[c][k] = 8'(8'h10 * c + k + 1);
            for (int k = 0; k < 3; k++) out_lane[c][k] = 16'(16'h0100 * c + k + 16'hA0);
        end
        in_lane[0][0] = 8'h90; in_lane[0][1] = 8'h78; in_lane[0][2] = 8'h56;
        in_lane[0][3] = 8'h34; in_lane[0][4] = 8'h12;
        out_lane[0][0] = 16'h3333; out_lane[0][1] = 16'h2222; out_lane[0][2] = 16'h1111;
        for (int k = 0; k < L; k++) begin pv[k] = 1'b0; pd[k] = 32'd0; end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_outs", {wen, ren, csa_in_wen, res_valid, done, err_timeout}, 6'd0);
        check("rst_res", {res_in, res_out}, 88'd0);
        rst_n = 1'b1;

        // Basic single-channel pass
        clear_logs(); pulse_start(); wait_end("t1");
        check_first_pass("t1");

        // BUSY reports 1 for five polls
        busy_cfg = 5; clear_logs(); pulse_start(); wait_end("t2");
        check("t2_nbusy", busy_rd.size(), 6);
        sp_ok = 1'b1;
        for (int i = 1; i < busy_rd.size(); i++) if (busy_rd[i] - busy_rd[i-1] != L + 1) sp_ok = 1'b0;
        check("t2_spacing", sp_ok, 1'b1);
        check("t2_err", err_timeout, 1'b0);
        check("t2_nfifo", fifo.size(), 2);

        // BUSY stuck
        busy_cfg = 100000; clear_logs(); pulse_start(); wait_end("t3");
        repeat (5) @(negedge clk);
        check("t3_nbusy", busy_rd.size(), 8);
        check("t3_err", err_timeout, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_nfifo", fifo.size(), 0);

        // FIFO full stall across pattern wrap; start leaves ERR
        busy_cfg = 0; cfg_words = 16'd4; cfg_seed = 40'hFF_FFFF_FFFE;
        clear_logs(); pulse_start();
        check("t4_err_clr", err_timeout, 1'b0);
        check("t4_busy", busy, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (csa_in_wen) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("t4_first_push", ok, 1'b1);
        csa_in_error_full = 1'b1;
        repeat (3) @(negedge clk);
        csa_in_error_full = 1'b0;
        wait_end("t4");
        check("t4_nfifo", fifo.size(), 4);
        if (fifo.size() == 4) begin
            check("t4_f0", fifo[0], 40'hFF_FFFF_FFFE);
            check("t4_f1", fifo[1], 40'hFF_FFFF_FFFF);
            check("t4_f2", fifo[2], 40'h0);
            check("t4_f3", fifo[3], 40'h1);
        end

        // Three channels, channel 1 has no output data; stray start ignored
        cfg_words = 16'd1; cfg_seed = 40'h0; cfg_num_ch = 3'd3; out_v[1] = 1'b0;
        clear_logs(); pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_end("t5");
        check("t5_nwr", wr_addr.size(), 4);
        if (wr_addr.size() == 4) begin
            check("t5_calc", wr_addr[0], 10'd13);
            check("t5_ch0", {wr_addr[1], wr_data[1]}, {10'd2, 32'd0});
            check("t5_ch1", {wr_addr[2], wr_data[2]}, {10'd2, 32'd1});
            check("t5_ch2", {wr_addr[3], wr_data[3]}, {10'd2, 32'd2});
        end
        check("t5_nres", r_ch.size(), 2);
        if (r_ch.size() == 2) begin
            check("t5_r0", r_ch[0], 2'd0);
            check("t5_r1", r_ch[1], 2'd2);
            check("t5_r1_in", r_in[1], 40'h25_2423_2221);
            check("t5_r1_out", r_out[1], 48'h02A2_02A1_02A0);
        end
        check("t5_done", done_cnt, 1);
        out_v[1] = 1'b1;

        // num_ch 0 treated as 1, zero words skips the push
        cfg_num_ch = 3'd0; cfg_words = 16'd0;
        clear_logs(); pulse_start(); wait_end("t6");
        check("t6_nwr", wr_addr.size(), 2);
        check("t6_nfifo", fifo.size(), 0);
        check("t6_nres", r_in.size(), 1);

        // Loop mode, reset during the input burst, then a fresh pass
        cfg_num_ch = 3'd1; cfg_words = 16'd2; cfg_loop = 1'b1;
        clear_logs(); pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ren && raddr == 10'd4) begin ok = 1'b1; break; end
        end
        check("t7_burst_seen", ok, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_rst_outs", {wen, ren, csa_in_wen, res_valid, done, busy, err_timeout}, 7'd0);
        check("t7_rst_res", {res_in, res_out}, 88'd0);
        pulse_cnt = 0;
        repeat (4) @(negedge clk);
        check("t7_no_pulses", pulse_cnt, 0);
        rst_n = 1'b1; cfg_loop = 1'b0;
        clear_logs(); pulse_start(); wait_end("t7");
        check_first_pass("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end
endmodule
